// File: rtl/busca_decod_if.sv
// Instruction-memory bus between the busca_decod core (master) and its memory (slave).
interface busca_decod_if;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  modport master (output mem_addr, output mem_req, input mem_ack, input mem_rdata);
  modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_rdata);
endinterface

// File: rtl/busca_decod.sv
// busca_decod: fetch/decode/execute control core for an 8-bit toy ISA.
// IR[7:4] opcode, IR[3:2] rs/rd, IR[1:0] rt. BEQ/JMP carry one target byte.
// Optional feature macro: BUSCA_DECOD_HALT_EN (opcode 1111 parks the core in PARADO;
// when undefined, 1111 is a NOP and halt stays 0).
module busca_decod (
  input  logic                clock,
  input  logic                reset,
  busca_decod_if.master       mem,
  input  logic                zero,
  output logic [1:0]          in1,
  output logic [1:0]          in2,
  output logic                inec,
  output logic                EscreveReg,
  output logic [1:0]          alu_op,
  output logic                halt
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  localparam logic [2:0] BUSCA     = 3'd0;
  localparam logic [2:0] DECOD     = 3'd1;
  localparam logic [2:0] EXEC      = 3'd2;
  localparam logic [2:0] BUSCA_IMM = 3'd3;
  localparam logic [2:0] PARADO    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          taken_q, taken_d;
  logic          req_q, req_d;
  logic          wr_q, wr_d;
  logic          halt_q, halt_d;

  logic [3:0] opcode;
  logic       is_alu, is_beq, is_jmp, is_halt;

  assign opcode = ir_q[7:4];
  assign is_alu = (opcode[3:2] == 2'b00);
  assign is_beq = (opcode == 4'h4);
  assign is_jmp = (opcode == 4'h5);
`ifdef BUSCA_DECOD_HALT_EN
  assign is_halt = (opcode == 4'hF);
`else
  assign is_halt = 1'b0;
`endif

  // Next-state, PC/IR updates and next-cycle output values.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    taken_d = taken_q;
    case (state_q)
      BUSCA: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = DECOD;
        end
      end
      DECOD: state_d = EXEC;
      EXEC: begin
        if (is_alu) begin
          state_d = BUSCA;
        end else if (is_beq || is_jmp) begin
          taken_d = is_jmp || (is_beq && zero);
          state_d = BUSCA_IMM;
        end else if (is_halt) begin
          state_d = PARADO;
        end else begin
          state_d = BUSCA;
        end
      end
      BUSCA_IMM: begin
        if (mem.mem_ack) begin
          pc_d    = taken_q ? mem.mem_rdata : pc_q + AW'(1);
          state_d = BUSCA;
        end
      end
      PARADO:  state_d = PARADO;
      default: state_d = BUSCA;
    endcase
    req_d  = (state_d == BUSCA) || (state_d == BUSCA_IMM);
    wr_d   = (state_d == EXEC) && (ir_d[7:6] == 2'b00);
    halt_d = (state_d == PARADO);
  end

  // State, datapath and output registers; reset wins over every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BUSCA;
      pc_q    <= '0;
      ir_q    <= '0;
      taken_q <= 1'b0;
      req_q   <= 1'b1;
      wr_q    <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      taken_q <= taken_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      halt_q  <= halt_d;
    end
  end

  assign mem.mem_addr = pc_q;
  assign mem.mem_req  = req_q;
  assign in1          = ir_q[3:2];
  assign in2          = ir_q[1:0];
  assign inec         = ir_q[2];
  assign alu_op       = ir_q[5:4];
  // Write enable is masked by reset so no register write lands on a reset edge.
  assign EscreveReg   = wr_q & ~reset;
  assign halt         = halt_q;

endmodule
